pwm_cmd_sched: RTL and testbench
================================

// Module: pwm_cmd_sched
// PURPOSE
//  Command scheduler between the UART packet decoder (dataA/dataB/dataC/dataD, recv_done) and CH_NUM pattern_pwm channels.
//  Decodes one command per packet and holds per-channel shadow configuration.
//  On START, copies the shadow set into the active set and drives pwm_en; stops channels on STOP or on finite-run completion.
//  Also owns the breath-LED enable.
// PARAMETERS
//  CH_NUM      2   number of pattern_pwm channels (1..8)
//  PAT_WIDTH   16  pattern register width, matches pattern_pwm _PAT_WIDTH
// PORTS
//  sys_clk        in   1             system clock (clk_50M domain)
//  sys_rst        in   1             synchronous reset, active-high
//  cmd_valid      in   1             1-cycle command strobe (recv_done)
//  cmd_op         in   8             opcode (dataA)
//  cmd_ch         in   8             channel index; 8'hFF = all channels (dataD)
//  cmd_arg0       in   16            argument 0 (dataB)
//  cmd_arg1       in   16            argument 1 (dataC)
//  cmd_ack        out  1             1-cycle pulse: command accepted
//  cmd_err        out  1             1-cycle pulse: command rejected
//  cmd_drop_cnt   out  8             saturating count of strobes dropped while busy
//  pwm_busy       in   CH_NUM        per-channel busy from pattern_pwm
//  pwm_valid      in   CH_NUM        per-channel end-of-run pulse from pattern_pwm
//  pwm_en         out  CH_NUM        per-channel enable
//  duty_num       out  8*CH_NUM      active duty, channel n at [8n+7:8n]
//  pulse_dessert  out  16*CH_NUM     active gap, channel n at [16n+15:16n]
//  pulse_num      out  8*CH_NUM      active pulse count (0 = infinite)
//  pat            out  PAT_WIDTH*CH_NUM  active pattern
//  led_enable     out  1             breath-LED gate
// BEHAVIOUR
//  Reset values:
//   - All outputs 0.
//   - Shadow registers: duty=1, dessert=1, pulse_num=0, pat=1.
//   - FSM in IDLE.
//  FSM IDLE -> DECODE -> EXEC -> IDLE:
//   - IDLE samples cmd_valid and latches op/ch/args.
//   - DECODE classifies the command and checks it.
//   - EXEC updates state and pulses exactly one of cmd_ack/cmd_err.
//   - Ack/err appears 3 cycles after the cmd_valid cycle.
//  cmd_valid in DECODE or EXEC:
//   - Strobe is ignored.
//   - cmd_drop_cnt increments, saturating at 8'hFF.
//  Opcodes:
//   - 8'h01 SET_TIMING: shadow dessert=arg0; duty=arg1[7:0]; pulse_num=arg1[15:8].
//   - 8'h02 SET_PAT: shadow pat=arg0[PAT_WIDTH-1:0], zero-extended if PAT_WIDTH>16.
//   - 8'h03 START: active<=shadow; pwm_en<=1.
//   - 8'h04 STOP: pwm_en<=0; active values unchanged.
//   - 8'h08 LED_ON: led_enable<=1. 8'h09 LED_OFF: led_enable<=0. cmd_ch is ignored.
//   - Any other opcode: cmd_err.
//  Channel rules:
//   - cmd_ch >= CH_NUM and != 8'hFF: cmd_err.
//   - 8'hFF applies the command to every channel.
//  SET_* on a running channel:
//   - Updates the shadow only; active outputs do not change.
//   - Takes effect at the next START.
//  START rejection:
//   - Rejected with cmd_err if any target channel has pwm_en=1 or pwm_busy=1.
//   - Broadcast START is atomic: on any conflict, no channel starts.
//  STOP on an idle channel: cmd_ack, no change.
//  Finite run:
//   - pwm_valid[n]=1 while pwm_en[n]=1 and active pulse_num[n]!=0 clears pwm_en[n] on the next edge.
//   - pwm_valid with pulse_num=0 is ignored.
//  Simultaneous events:
//   - pwm_valid[n] and a STOP on n in EXEC: pwm_en[n]=0, STOP acked.
//   - pwm_valid[n] and a START on n in EXEC: START was already rejected at DECODE (en=1).
//  Reset mid-command: FSM returns to IDLE; no ack/err is emitted.
// TESTING
//  1. Reset -> all outputs 0; START ch0 with defaults -> ack at +3; pwm_en=2'b01, duty0=1, dessert0=1, pat0=16'h0001.
//  2. SET_TIMING ch1 arg0=16'h0010, arg1=16'h0305, then START ch1 -> duty1=5, pulse_num1=3, dessert1=16; pwm_valid[1] -> pwm_en[1]=0 next edge.
//  3. ch0 running: SET_PAT ch0 16'hA5A5 -> ack, pat0 unchanged; STOP, then START once busy=0 -> pat0=16'hA5A5.
//  4. Broadcast START with pwm_busy=2'b10 -> cmd_err, pwm_en stays 00; op 8'h77 -> err; cmd_ch=5 -> err.
//  5. cmd_valid on 2 consecutive cycles -> first ack, cmd_drop_cnt=1; 300 dropped strobes -> saturates at 255.
//  6. LED_ON -> led_enable=1; sys_rst during DECODE -> no ack, led_enable=0, FSM IDLE.

Source files
------------

// File: rtl/pwm_cmd_sched.sv
// Command scheduler: decodes one UART packet per command into per-channel shadow
// configuration and starts/stops pattern_pwm channels from an active copy of it.
module pwm_cmd_sched #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned PAT_WIDTH = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          cmd_valid_i,
  input  logic [7:0]                    cmd_op_i,
  input  logic [7:0]                    cmd_ch_i,
  input  logic [15:0]                   cmd_arg0_i,
  input  logic [15:0]                   cmd_arg1_i,
  output logic                          cmd_ack_o,
  output logic                          cmd_err_o,
  output logic [7:0]                    cmd_drop_cnt_o,
  input  logic [CH_NUM-1:0]             pwm_busy_i,
  input  logic [CH_NUM-1:0]             pwm_valid_i,
  output logic [CH_NUM-1:0]             pwm_en_o,
  output logic [8*CH_NUM-1:0]           duty_num_o,
  output logic [16*CH_NUM-1:0]          pulse_dessert_o,
  output logic [8*CH_NUM-1:0]           pulse_num_o,
  output logic [PAT_WIDTH*CH_NUM-1:0]   pat_o,
  output logic                          led_enable_o
);

  localparam logic [7:0] OpcSetTiming = 8'h01;
  localparam logic [7:0] OpcSetPat    = 8'h02;
  localparam logic [7:0] OpcStart     = 8'h03;
  localparam logic [7:0] OpcStop      = 8'h04;
  localparam logic [7:0] OpcLedOn     = 8'h08;
  localparam logic [7:0] OpcLedOff    = 8'h09;
  localparam logic [7:0] ChAll        = 8'hFF;
  localparam int unsigned PatCopy     = (PAT_WIDTH < 16) ? PAT_WIDTH : 16;

  typedef enum logic [1:0] {StIdle, StDecode, StExec} state_e;
  typedef enum logic [2:0] {
    OpTiming, OpPat, OpStart, OpStop, OpLedOn, OpLedOff, OpBad
  } op_e;

  state_e state_q;
  logic [7:0]  op_q, ch_q;
  logic [15:0] arg0_q, arg1_q;
  op_e         kind_q;
  logic [CH_NUM-1:0] tgt_q;
  logic        rej_q;
  logic        cmd_ack_q, cmd_err_q, led_q;
  logic [7:0]  drop_q;
  logic [CH_NUM-1:0] pwm_en_q, pwm_en_d;

  logic [7:0]           sh_duty_q    [CH_NUM];
  logic [15:0]          sh_dessert_q [CH_NUM];
  logic [7:0]           sh_pnum_q    [CH_NUM];
  logic [PAT_WIDTH-1:0] sh_pat_q     [CH_NUM];
  logic [7:0]           act_duty_q    [CH_NUM];
  logic [15:0]          act_dessert_q [CH_NUM];
  logic [7:0]           act_pnum_q    [CH_NUM];
  logic [PAT_WIDTH-1:0] act_pat_q     [CH_NUM];

  op_e               kind;
  logic [CH_NUM-1:0] tgt, fin_clr;
  logic              ch_ok, is_led, dec_err;
  logic [PAT_WIDTH-1:0] pat_arg;

  // Classify the latched command; the decision is registered for EXEC.
  always_comb begin
    kind = OpBad;
    case (op_q)
      OpcSetTiming: kind = OpTiming;
      OpcSetPat:    kind = OpPat;
      OpcStart:     kind = OpStart;
      OpcStop:      kind = OpStop;
      OpcLedOn:     kind = OpLedOn;
      OpcLedOff:    kind = OpLedOff;
      default:      kind = OpBad;
    endcase
    tgt = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (ch_q == ChAll || ch_q == 8'(n)) tgt[n] = 1'b1;
    end
    ch_ok   = (ch_q == ChAll) || (ch_q < 8'(CH_NUM));
    is_led  = (kind == OpLedOn) || (kind == OpLedOff);
    // Broadcast START is all-or-nothing: one conflicting channel rejects it.
    dec_err = (kind == OpBad) || (!is_led && !ch_ok) ||
              ((kind == OpStart) && |(tgt & (pwm_en_q | pwm_busy_i)));
  end

  always_comb begin
    pat_arg = '0;
    pat_arg[PatCopy-1:0] = arg0_q[PatCopy-1:0];
  end

  always_comb begin
    for (int n = 0; n < CH_NUM; n++) begin
      fin_clr[n] = pwm_valid_i[n] && pwm_en_q[n] && (act_pnum_q[n] != 8'd0);
    end
    pwm_en_d = pwm_en_q & ~fin_clr;
    if (state_q == StExec && !rej_q) begin
      if (kind_q == OpStart) pwm_en_d = pwm_en_d | tgt_q;
      if (kind_q == OpStop)  pwm_en_d = pwm_en_d & ~tgt_q;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      ch_q      <= '0;
      arg0_q    <= '0;
      arg1_q    <= '0;
      kind_q    <= OpBad;
      tgt_q     <= '0;
      rej_q     <= 1'b0;
      cmd_ack_q <= 1'b0;
      cmd_err_q <= 1'b0;
      led_q     <= 1'b0;
      drop_q    <= '0;
      pwm_en_q  <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        sh_duty_q[n]     <= 8'd1;
        sh_dessert_q[n]  <= 16'd1;
        sh_pnum_q[n]     <= 8'd0;
        sh_pat_q[n]      <= PAT_WIDTH'(1);
        act_duty_q[n]    <= '0;
        act_dessert_q[n] <= '0;
        act_pnum_q[n]    <= '0;
        act_pat_q[n]     <= '0;
      end
    end else begin
      cmd_ack_q <= 1'b0;
      cmd_err_q <= 1'b0;
      pwm_en_q  <= pwm_en_d;
      if (cmd_valid_i && state_q != StIdle && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            op_q    <= cmd_op_i;
            ch_q    <= cmd_ch_i;
            arg0_q  <= cmd_arg0_i;
            arg1_q  <= cmd_arg1_i;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          kind_q  <= kind;
          tgt_q   <= tgt;
          rej_q   <= dec_err;
          state_q <= StExec;
        end
        StExec: begin
          state_q <= StIdle;
          if (rej_q) begin
            cmd_err_q <= 1'b1;
          end else begin
            cmd_ack_q <= 1'b1;
            unique case (kind_q)
              OpTiming: begin
                for (int n = 0; n < CH_NUM; n++) begin
                  if (tgt_q[n]) begin
                    sh_dessert_q[n] <= arg0_q;
                    sh_duty_q[n]    <= arg1_q[7:0];
                    sh_pnum_q[n]    <= arg1_q[15:8];
                  end
                end
              end
              OpPat: begin
                for (int n = 0; n < CH_NUM; n++) begin
                  if (tgt_q[n]) sh_pat_q[n] <= pat_arg;
                end
              end
              OpStart: begin
                for (int n = 0; n < CH_NUM; n++) begin
                  if (tgt_q[n]) begin
                    act_duty_q[n]    <= sh_duty_q[n];
                    act_dessert_q[n] <= sh_dessert_q[n];
                    act_pnum_q[n]    <= sh_pnum_q[n];
                    act_pat_q[n]     <= sh_pat_q[n];
                  end
                end
              end
              OpLedOn:  led_q <= 1'b1;
              OpLedOff: led_q <= 1'b0;
              OpStop, OpBad: ;
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    for (int n = 0; n < CH_NUM; n++) begin
      duty_num_o[8*n +: 8]             = act_duty_q[n];
      pulse_dessert_o[16*n +: 16]      = act_dessert_q[n];
      pulse_num_o[8*n +: 8]            = act_pnum_q[n];
      pat_o[PAT_WIDTH*n +: PAT_WIDTH]  = act_pat_q[n];
    end
  end

  assign cmd_ack_o      = cmd_ack_q;
  assign cmd_err_o      = cmd_err_q;
  assign cmd_drop_cnt_o = drop_q;
  assign pwm_en_o       = pwm_en_q;
  assign led_enable_o   = led_q;

endmodule

// File: tb/tb_pwm_cmd_sched.sv
// Bench for pwm_cmd_sched: expected ack/err and response cycle are queued at issue time
// and checked when the DUT responds; register effects are checked against constants.
module tb_pwm_cmd_sched;

  localparam int unsigned ChNum = 2;
  localparam int unsigned PatW  = 16;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic [7:0] cmd_op, cmd_ch;
  logic [15:0] cmd_arg0, cmd_arg1;
  logic cmd_ack, cmd_err;
  logic [7:0] drop_cnt;
  logic [ChNum-1:0] pwm_busy, pwm_valid, pwm_en;
  logic [8*ChNum-1:0] duty_num, pulse_num;
  logic [16*ChNum-1:0] pulse_dessert;
  logic [PatW*ChNum-1:0] pat;
  logic led_enable;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic err;
    int   cyc;
  } exp_t;
  exp_t sb_q[$];

  pwm_cmd_sched #(.CH_NUM(ChNum), .PAT_WIDTH(PatW)) u_dut (
    .sys_clk_i      (clk),
    .sys_rst_i      (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_op_i       (cmd_op),
    .cmd_ch_i       (cmd_ch),
    .cmd_arg0_i     (cmd_arg0),
    .cmd_arg1_i     (cmd_arg1),
    .cmd_ack_o      (cmd_ack),
    .cmd_err_o      (cmd_err),
    .cmd_drop_cnt_o (drop_cnt),
    .pwm_busy_i     (pwm_busy),
    .pwm_valid_i    (pwm_valid),
    .pwm_en_o       (pwm_en),
    .duty_num_o     (duty_num),
    .pulse_dessert_o(pulse_dessert),
    .pulse_num_o    (pulse_num),
    .pat_o          (pat),
    .led_enable_o   (led_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every ack/err must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (cmd_ack || cmd_err)) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_resp", {62'd0, cmd_ack, cmd_err}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("resp_ack_err", {62'd0, cmd_ack, cmd_err}, {62'd0, ~e.err, e.err});
        check_eq("resp_latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_eq("resp_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic send(input logic [7:0] op, input logic [7:0] ch, input logic [15:0] a0,
                      input logic [15:0] a1, input logic exp_err, input int hold);
    @(posedge clk);
    #1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_arg0  = a0;
    cmd_arg1  = a1;
    cmd_valid = 1'b1;
    sb_q.push_back('{err: exp_err, cyc: cyc + 3});
    repeat (hold) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  task automatic pulse_valid(input logic [ChNum-1:0] v);
    @(posedge clk);
    #1;
    pwm_valid = v;
    @(posedge clk);
    #1;
    pwm_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_ch = '0;
    cmd_arg0 = '0;
    cmd_arg1 = '0;
    pwm_busy = '0;
    pwm_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_en", pwm_en, 0);
    check_eq("rst_duty", duty_num, 0);
    check_eq("rst_dessert", pulse_dessert, 0);
    check_eq("rst_pnum", pulse_num, 0);
    check_eq("rst_pat", pat, 0);
    check_eq("rst_led", led_enable, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_ackerr", {cmd_ack, cmd_err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Default shadow start on channel 0.
    send(8'h03, 8'd0, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t1_en", pwm_en, 2'b01);
    check_eq("t1_duty0", duty_num[7:0], 8'd1);
    check_eq("t1_dessert0", pulse_dessert[15:0], 16'd1);
    check_eq("t1_pat0", pat[15:0], 16'h0001);
    check_eq("t1_pnum0", pulse_num[7:0], 8'd0);
    check_eq("t1_duty1", duty_num[15:8], 8'd0);

    // Finite run on channel 1.
    send(8'h01, 8'd1, 16'h0010, 16'h0305, 1'b0, 1);
    check_eq("t2_duty1_shadow_only", duty_num[15:8], 8'd0);
    send(8'h03, 8'd1, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t2_en", pwm_en, 2'b11);
    check_eq("t2_duty1", duty_num[15:8], 8'd5);
    check_eq("t2_pnum1", pulse_num[15:8], 8'd3);
    check_eq("t2_dessert1", pulse_dessert[31:16], 16'h0010);
    pulse_valid(2'b10);
    check_eq("t2_fin_clear", pwm_en, 2'b01);
    pulse_valid(2'b01);
    check_eq("t2_inf_ignore", pwm_en, 2'b01);

    // Shadow update while running, restart rules.
    send(8'h02, 8'd0, 16'hA5A5, 16'h0, 1'b0, 1);
    check_eq("t3_pat0_held", pat[15:0], 16'h0001);
    send(8'h03, 8'd0, 16'h0, 16'h0, 1'b1, 1);
    send(8'h04, 8'd0, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t3_stop_en", pwm_en, 2'b00);
    check_eq("t3_stop_keeps_duty", duty_num[7:0], 8'd1);
    pwm_busy = 2'b01;
    send(8'h03, 8'd0, 16'h0, 16'h0, 1'b1, 1);
    check_eq("t3_busy_en", pwm_en, 2'b00);
    pwm_busy = 2'b00;
    send(8'h03, 8'd0, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t3_pat0_new", pat[15:0], 16'hA5A5);
    check_eq("t3_en", pwm_en, 2'b01);
    send(8'h04, 8'hFF, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t3_stop_all", pwm_en, 2'b00);
    send(8'h04, 8'd1, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t3_stop_idle", pwm_en, 2'b00);

    // Rejections.
    pwm_busy = 2'b10;
    send(8'h03, 8'hFF, 16'h0, 16'h0, 1'b1, 1);
    check_eq("t4_bcast_atomic", pwm_en, 2'b00);
    pwm_busy = 2'b00;
    send(8'h77, 8'd0, 16'h0, 16'h0, 1'b1, 1);
    send(8'h03, 8'd5, 16'h0, 16'h0, 1'b1, 1);
    check_eq("t4_badch_en", pwm_en, 2'b00);
    send(8'h09, 8'd5, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t4_led_off", led_enable, 1'b0);

    // Dropped strobes.
    send(8'h08, 8'd0, 16'h0, 16'h0, 1'b0, 2);
    check_eq("t5_drop1", drop_cnt, 8'd1);
    check_eq("t5_led_on", led_enable, 1'b1);
    for (int i = 0; i < 150; i++) begin
      send(8'h08, 8'd0, 16'h0, 16'h0, 1'b0, 3);
      if (i == 9) check_eq("t5_drop21", drop_cnt, 8'd21);
    end
    check_eq("t5_drop_sat", drop_cnt, 8'd255);

    // LED and reset mid-command.
    send(8'h09, 8'd0, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t6_led_off", led_enable, 1'b0);
    send(8'h08, 8'd0, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t6_led_on", led_enable, 1'b1);
    send(8'h03, 8'd1, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t6_en", pwm_en, 2'b10);
    @(posedge clk);
    #1;
    cmd_op = 8'h04;
    cmd_ch = 8'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_led", led_enable, 1'b0);
    check_eq("t6_rst_en", pwm_en, 2'b00);
    check_eq("t6_rst_drop", drop_cnt, 8'd0);
    check_eq("t6_rst_duty", duty_num, 0);
    repeat (5) @(negedge clk);
    send(8'h08, 8'd0, 16'h0, 16'h0, 1'b0, 1);
    check_eq("t6_idle_after_rst", led_enable, 1'b1);

    wait_idle();
    check_eq("sb_pending", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
